wrr_arbiter: RTL and testbench
==============================

# wrr_arbiter

Parametrised weighted round-robin arbiter with an ack handshake. It is the successor to the plain round-robin arbiter. Each of WIDTH requesters receives a run-time programmable number of consecutive acknowledged grants (its weight) before priority rotates. The grant is registered and held until the owner acks or abandons. It sits between request sources and a shared resource that signals completion via ack.

## Interface
- WIDTH, 4: number of requesters (≥2).
- WEIGHT_W, 3: width of each per-requester weight field.
- IDX_W, $clog2(WIDTH): width of grant_idx (derived; do not override).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- resetb  in  1  synchronous, active-high reset. resetb=1 at a clk edge resets the block.
- request  in  WIDTH  per-requester request; level-sensitive, bit i = requester i.
- ack  in  1  resource has completed one transfer for the current grant holder.
- weights  in  WIDTH*WEIGHT_W  weight of requester i at bits [i*WEIGHT_W +: WEIGHT_W]; value 0 treated as 1.
- grant  out  WIDTH  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  registered; equals |grant.
- grant_idx  out  IDX_W  registered binary index of the holder; 0 when idle.

## Operation
- State: FSM {IDLE, GRANT}, rotation pointer ptr (IDX_W bits), current holder cur, credit counter credit (WEIGHT_W bits).
- Selection: the first set request bit scanning circularly from ptr upward, wrapping WIDTH-1→0. ptr itself has highest priority.
- Loading a grant:
  - grant=onehot(sel), grant_idx=sel, cur=sel.
  - credit = weights[sel], or 1 if that field is 0.
  - Weights are sampled only at load; changes mid-burst are ignored.
- IDLE:
  - request==0: stay in IDLE, outputs 0.
  - Otherwise: load a grant, go to GRANT.
- GRANT, ack=1 and request[cur]=1: credit decrements.
  - New credit >0: hold the same grant (burst continues).
  - New credit ==0: release.
- GRANT, ack=0 and request[cur]=1: hold grant and credit unchanged, indefinitely.
- GRANT, request[cur]=0 (with or without ack): abandonment. Release immediately, regardless of remaining credit.
- Release:
  - Set ptr = cur+1 mod WIDTH.
  - Select from request with the new ptr, excluding cur. cur is eligible only if it is the sole requester, as the last in circular order.
  - Any selectable requester: load its grant, stay in GRANT. This is back-to-back with no idle cycle.
  - None: go to IDLE, clear outputs.
- ack in IDLE: ignored.
- ack and request drop on the same cycle: treated as abandonment, with identical outcome.
- Only one requester ever granted; grant is never multi-hot.

## Timing
- All outputs registered. Reset values: grant=0, grant_valid=0, grant_idx=0; internal ptr=0, credit=0, state IDLE.
- Latency from IDLE: request seen at edge N produces grant visible after edge N (one cycle, request→grant).
- Ack seen at edge N:
  - Credit update and any grant switch are visible after edge N.
  - The new holder's grant directly replaces the old; no bubble.
- Continuous ack with weight w and request held: holder owns the grant for exactly w ack cycles.
- Abandonment: the grant drops or switches at the first edge where request[cur]=0 is sampled.
- Reset mid-burst: at the reset edge, outputs clear and ptr returns to 0. The first grant after reset follows the IDLE rules.

## Test plan
- Reset: resetb=1 for 2 cycles with request=4'b1111 → grant=0000, grant_valid=0, grant_idx=0 throughout. Release reset → grant=0001 the next cycle.
- Basic rotation, weights all 1, request=4'b1010, ack=1 continuously → grant sequence 0010, 1000, 0010, 1000 on consecutive cycles.
- Weighted burst, weights={1,1,3,1} (requester 1 = 3), request=4'b1010, ack=1 → grant 0010 for 3 cycles, 1000 for 1 cycle, then 0010 ×3 again.
- Hold: request=4'b0111, grant=0001, ack=0 for 5 cycles → grant stays 0001. A single ack pulse → grant 0010 next cycle.
- Abandonment: grant=0100 with credit 3 remaining, request[2] drops, request=4'b1000 → grant=1000 next cycle. Then request=0 → IDLE, grant=0000.
- Zero weight, sole requester, reset mid-burst:
  - weights[3]=0, request=4'b1000, ack=1 → grant stays 1000, re-granted each ack with no idle cycle.
  - Assert resetb mid-burst → grant=0000 the following cycle.

Source files
------------

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each requester holds a registered one-hot grant
// for up to its weight in acked transfers before priority rotates past it.
module wrr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int WEIGHT_W = 3,
  parameter int IDX_W    = $clog2(WIDTH)
) (
  input  logic                        clk,
  input  logic                        resetb,
  input  logic [WIDTH-1:0]            request,
  input  logic                        ack,
  input  logic [WIDTH*WEIGHT_W-1:0]   weights,
  output logic [WIDTH-1:0]            grant,
  output logic                        grant_valid,
  output logic [IDX_W-1:0]            grant_idx
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_n;
  logic [IDX_W-1:0]     ptr, ptr_n;
  logic [IDX_W-1:0]     cur, cur_n;
  logic [WEIGHT_W-1:0]  credit, credit_n;
  logic [WIDTH-1:0]     grant_n;
  logic                 grant_valid_n;
  logic [IDX_W-1:0]     grant_idx_n;
  logic [IDX_W:0]       sel;
  logic                 load;
  logic                 rel;

  // Circular scan from start; returns {found, index}. Scanning downward lets the
  // lowest circular offset win without an early exit.
  function automatic logic [IDX_W:0] pick(input logic [WIDTH-1:0] req,
                                          input logic [IDX_W-1:0] start);
    logic [IDX_W:0] r;
    int             j;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      j = (int'(start) + i) % WIDTH;
      if (req[j]) r = {1'b1, IDX_W'(j)};
    end
    return r;
  endfunction

  function automatic logic [WEIGHT_W-1:0] credit_of(input logic [WIDTH*WEIGHT_W-1:0] w,
                                                    input logic [IDX_W-1:0] idx);
    logic [WEIGHT_W-1:0] f;
    f = w[idx*WEIGHT_W +: WEIGHT_W];
    return (f == '0) ? WEIGHT_W'(1) : f;
  endfunction

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    cur_n    = cur;
    credit_n = credit;
    sel      = '0;
    load     = 1'b0;
    rel      = 1'b0;

    case (state)
      IDLE: begin
        sel  = pick(request, ptr);
        load = sel[IDX_W];
      end
      GRANT: begin
        if (!request[cur]) begin
          rel = 1'b1;
        end else if (ack) begin
          credit_n = credit - WEIGHT_W'(1);
          if (credit_n == '0) rel = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Rotating past cur leaves cur last in scan order, so it only wins when alone.
    if (rel) begin
      ptr_n = (cur == IDX_W'(WIDTH - 1)) ? '0 : cur + IDX_W'(1);
      sel   = pick(request, ptr_n);
      load  = sel[IDX_W];
      if (!load) begin
        state_n  = IDLE;
        credit_n = '0;
      end
    end

    if (load) begin
      state_n  = GRANT;
      cur_n    = sel[IDX_W-1:0];
      credit_n = credit_of(weights, sel[IDX_W-1:0]);
    end

    grant_valid_n = (state_n == GRANT);
    grant_n       = grant_valid_n ? (WIDTH'(1) << cur_n) : '0;
    grant_idx_n   = grant_valid_n ? cur_n : '0;
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (resetb) begin
      state       <= IDLE;
      ptr         <= '0;
      cur         <= '0;
      credit      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cur         <= cur_n;
      credit      <= credit_n;
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      grant_idx   <= grant_idx_n;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: a driver queues the grant expected after each
// edge, and a negedge monitor pops and compares it against the DUT outputs.
module tb_wrr_arbiter;

  localparam int WIDTH    = 4;
  localparam int WEIGHT_W = 3;
  localparam int IDX_W    = 2;

  logic                      clk = 1'b0;
  logic                      resetb;
  logic [WIDTH-1:0]          request;
  logic                      ack;
  logic [WIDTH*WEIGHT_W-1:0] weights;
  logic [WIDTH-1:0]          grant;
  logic                      grant_valid;
  logic [IDX_W-1:0]          grant_idx;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] g;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   cycnt  = 0;
  int   checks = 0;
  int   errors = 0;

  wrr_arbiter #(.WIDTH(WIDTH), .WEIGHT_W(WEIGHT_W)) dut (
    .clk(clk), .resetb(resetb), .request(request), .ack(ack), .weights(weights),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycnt <= cycnt + 1;

  // Monitor: compare every expectation whose cycle has arrived
  always @(negedge clk) begin
    exp_t             e;
    logic [IDX_W-1:0] ei;
    while (sb.size() > 0 && sb[0].cyc <= cycnt) begin
      e  = sb.pop_front();
      ei = '0;
      for (int i = 0; i < WIDTH; i++) if (e.g[i]) ei = IDX_W'(i);
      checks++;
      if (grant !== e.g) begin
        errors++;
        $display("FAIL %s grant: got %b expected %b (cycle %0d)", e.name, grant, e.g, cycnt);
      end
      checks++;
      if (grant_valid !== (|e.g)) begin
        errors++;
        $display("FAIL %s grant_valid: got %b expected %b (cycle %0d)", e.name, grant_valid, |e.g, cycnt);
      end
      checks++;
      if (grant_idx !== ei) begin
        errors++;
        $display("FAIL %s grant_idx: got %0d expected %0d (cycle %0d)", e.name, grant_idx, ei, cycnt);
      end
    end
  end

  // Drive inputs for the next edge and queue the grant expected after it.
  task automatic step(input logic rst, input logic [WIDTH-1:0] req, input logic a,
                      input logic [WIDTH-1:0] exp_g, input string name);
    exp_t e;
    resetb  = rst;
    request = req;
    ack     = a;
    e.cyc   = cycnt + 1;
    e.g     = exp_g;
    e.name  = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // weights packed as {w3, w2, w1, w0}
  function automatic logic [WIDTH*WEIGHT_W-1:0] wts(input int w3, input int w2,
                                                    input int w1, input int w0);
    return {WEIGHT_W'(w3), WEIGHT_W'(w2), WEIGHT_W'(w1), WEIGHT_W'(w0)};
  endfunction

  initial begin
    resetb  = 1'b1;
    request = '0;
    ack     = 1'b0;
    weights = wts(1, 1, 1, 1);
    @(posedge clk);
    #1;

    // Reset holds outputs low even with every requester active
    step(1'b1, 4'b1111, 1'b0, 4'b0000, "reset0");
    step(1'b1, 4'b1111, 1'b0, 4'b0000, "reset1");
    step(1'b0, 4'b1111, 1'b0, 4'b0001, "reset_release");

    // Basic rotation, unit weights
    step(1'b1, 4'b0000, 1'b0, 4'b0000, "rot_rst");
    step(1'b0, 4'b1010, 1'b1, 4'b0010, "rot0");
    step(1'b0, 4'b1010, 1'b1, 4'b1000, "rot1");
    step(1'b0, 4'b1010, 1'b1, 4'b0010, "rot2");
    step(1'b0, 4'b1010, 1'b1, 4'b1000, "rot3");

    // Weighted burst: requester 1 weight 3
    step(1'b1, 4'b0000, 1'b0, 4'b0000, "wt_rst");
    weights = wts(1, 1, 3, 1);
    step(1'b0, 4'b1010, 1'b1, 4'b0010, "wt0");
    step(1'b0, 4'b1010, 1'b1, 4'b0010, "wt1");
    step(1'b0, 4'b1010, 1'b1, 4'b0010, "wt2");
    step(1'b0, 4'b1010, 1'b1, 4'b1000, "wt3");
    step(1'b0, 4'b1010, 1'b1, 4'b0010, "wt4");
    step(1'b0, 4'b1010, 1'b1, 4'b0010, "wt5");
    step(1'b0, 4'b1010, 1'b1, 4'b0010, "wt6");
    step(1'b0, 4'b1010, 1'b1, 4'b1000, "wt7");

    // Hold without ack, then a single ack pulse rotates
    step(1'b1, 4'b0000, 1'b0, 4'b0000, "hold_rst");
    weights = wts(1, 1, 1, 1);
    step(1'b0, 4'b0111, 1'b0, 4'b0001, "hold_load");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0111, 1'b0, 4'b0001, "hold");
    step(1'b0, 4'b0111, 1'b1, 4'b0010, "hold_ack");
    step(1'b0, 4'b0111, 1'b0, 4'b0010, "hold_after");

    // Abandonment with credit remaining, then idle, then ack+drop together
    step(1'b1, 4'b0000, 1'b0, 4'b0000, "abn_rst");
    weights = wts(1, 3, 1, 1);
    step(1'b0, 4'b0100, 1'b0, 4'b0100, "abn_load");
    step(1'b0, 4'b1000, 1'b0, 4'b1000, "abn_switch");
    step(1'b0, 4'b0000, 1'b0, 4'b0000, "abn_idle");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, "idle_ack");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, "abn_reload");
    step(1'b0, 4'b0001, 1'b1, 4'b0001, "abn_ack_drop");

    // Zero weight acts as one; sole requester re-granted back to back; reset mid-burst
    step(1'b1, 4'b0000, 1'b0, 4'b0000, "zw_rst");
    weights = wts(0, 1, 1, 1);
    step(1'b0, 4'b1000, 1'b1, 4'b1000, "zw0");
    step(1'b0, 4'b1000, 1'b1, 4'b1000, "zw1");
    step(1'b0, 4'b1000, 1'b1, 4'b1000, "zw2");
    step(1'b1, 4'b1000, 1'b1, 4'b0000, "zw_reset");
    step(1'b0, 4'b1000, 1'b1, 4'b1000, "zw_after");

    request = '0;
    ack     = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
